door_motor_drive: RTL



---
 rtl/door_motor_drive_if.sv | 31 +++
 rtl/door_motor_drive.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/door_motor_drive_if.sv
// ---------------------------------------------------------------------------
// door_motor_drive_if
// Groups the motor-drive command inputs and bridge-drive outputs.
//   M        : 2-bit FSM motor command (00 stop, 01 up, 10 down, 11 stop)
//   UpperLS  : upper limit switch, active-high
//   LowerLS  : lower limit switch, active-high
//   PwmUp    : up-leg PWM drive
//   PwmDown  : down-leg PWM drive
//   Moving   : active direction while ramping/running, else 00
//   Fault    : latched travel-timeout indication
// Modports: master (command source / observer), slave (the drive block).
// ---------------------------------------------------------------------------
interface door_motor_drive_if;
  logic [1:0] M;
  logic       UpperLS;
  logic       LowerLS;
  logic       PwmUp;
  logic       PwmDown;
  logic [1:0] Moving;
  logic       Fault;

  modport master (
    output M, UpperLS, LowerLS,
    input  PwmUp, PwmDown, Moving, Fault
  );

  modport slave (
    input  M, UpperLS, LowerLS,
    output PwmUp, PwmDown, Moving, Fault
  );
endinterface

// File: rtl/door_motor_drive.sv
// ---------------------------------------------------------------------------
// door_motor_drive
// Turns the garage-door FSM motor command into two mutually exclusive PWM
// bridge drives with soft-start duty ramping, dead-time on every stop or
// reversal, limit-switch cut-off and (optionally) a travel-timeout fault.
// Ports:
//   Clock   : system clock, rising edge
//   Reset_n : synchronous active-low reset
//   bus     : door_motor_drive_if.slave (M, UpperLS, LowerLS in;
//             PwmUp, PwmDown, Moving, Fault out, all registered)
// Configuration macro: MOTOR_TIMEOUT_EN -- when defined, a travel counter
// forces FAULT after TIMEOUT_CYCLES cycles in RAMP+RUN; otherwise Fault is 0.
// ---------------------------------------------------------------------------
module door_motor_drive #(
  parameter int PWM_BITS       = 8,
  parameter int RAMP_DIV       = 1024,
  parameter int DEAD_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic               Clock,
  input  logic               Reset_n,
  door_motor_drive_if.slave  bus
);

  localparam int DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [PWM_BITS-1:0] DUTY_ZERO     = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] DUTY_ONE      = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] DUTY_PRE_FULL = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [DIV_W-1:0]    DIV_ZERO      = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0]    DIV_ONE       = DIV_W'(1);
  localparam logic [DIV_W-1:0]    DIV_LAST      = DIV_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0]   DEAD_ZERO     = {DEAD_W{1'b0}};
  localparam logic [DEAD_W-1:0]   DEAD_ONE      = DEAD_W'(1);
  localparam logic [DEAD_W-1:0]   DEAD_LAST     = DEAD_W'(DEAD_CYCLES - 1);

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DEAD  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [1:0]          dir_r, dir_s;
  logic [PWM_BITS-1:0] duty_r, duty_s;
  logic [DIV_W-1:0]    div_r, div_s;
  logic [DEAD_W-1:0]   dead_r, dead_s;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic                pwm_up_r, pwm_down_r, fault_r;
  logic [1:0]          moving_r;

  logic                start_ok_s;
  logic                abort_s;
  logic                timeout_s;
  logic                driving_s;

`ifdef MOTOR_TIMEOUT_EN
  localparam int TRAVEL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TRAVEL_W-1:0] TRAVEL_ZERO = {TRAVEL_W{1'b0}};
  localparam logic [TRAVEL_W-1:0] TRAVEL_ONE  = TRAVEL_W'(1);
  localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TIMEOUT_CYCLES - 1);
  logic [TRAVEL_W-1:0] travel_r, travel_s;

  // Timeout fires on the cycle the travel counter would reach TIMEOUT_CYCLES.
  assign timeout_s = (travel_r == TRAVEL_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // A start needs a real direction whose own limit switch is still open.
  assign start_ok_s = ((bus.M == DIR_UP)   && !bus.UpperLS) ||
                      ((bus.M == DIR_DOWN) && !bus.LowerLS);

  // Any command other than the latched direction (stop, 11, reversal) or the
  // latched direction's limit switch ends the travel.
  assign abort_s = (bus.M != dir_r) ||
                   ((dir_r == DIR_UP) ? bus.UpperLS : bus.LowerLS);

  assign driving_s = (state_r == ST_RAMP) || (state_r == ST_RUN);

  // Next-state and datapath update for the drive FSM.
  always_comb begin
    state_s = state_r;
    dir_s   = dir_r;
    duty_s  = duty_r;
    div_s   = div_r;
    dead_s  = dead_r;
`ifdef MOTOR_TIMEOUT_EN
    travel_s = travel_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_s = ST_RAMP;
          dir_s   = bus.M;
          duty_s  = DUTY_ZERO;
          div_s   = DIV_ZERO;
`ifdef MOTOR_TIMEOUT_EN
          travel_s = TRAVEL_ZERO;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RAMP, ST_RUN: begin
        if (timeout_s) begin
          state_s = ST_FAULT;
          duty_s  = DUTY_ZERO;
        end else if (abort_s) begin
          state_s = ST_DEAD;
          duty_s  = DUTY_ZERO;
          dead_s  = DEAD_ZERO;
        end else begin
`ifdef MOTOR_TIMEOUT_EN
          travel_s = travel_r + TRAVEL_ONE;
`endif
          if ((state_r == ST_RAMP) && (div_r == DIV_LAST)) begin
            div_s  = DIV_ZERO;
            duty_s = duty_r + DUTY_ONE;
            // The increment that lands on full duty also leaves RAMP.
            if (duty_r == DUTY_PRE_FULL) begin
              state_s = ST_RUN;
            end else begin
              state_s = ST_RAMP;
            end
          end else if (state_r == ST_RAMP) begin
            div_s = div_r + DIV_ONE;
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      ST_DEAD: begin
        if (dead_r == DEAD_LAST) begin
          state_s = ST_IDLE;
        end else begin
          dead_s = dead_r + DEAD_ONE;
        end
      end
      ST_FAULT: begin
        if (bus.M == DIR_NONE) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FAULT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        duty_s  = DUTY_ZERO;
      end
    endcase
  end

  // State, counters and registered outputs; outputs lag the state by a cycle.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_r    <= ST_IDLE;
      dir_r      <= DIR_NONE;
      duty_r     <= DUTY_ZERO;
      div_r      <= DIV_ZERO;
      dead_r     <= DEAD_ZERO;
      pwm_cnt_r  <= DUTY_ZERO;
      pwm_up_r   <= 1'b0;
      pwm_down_r <= 1'b0;
      moving_r   <= DIR_NONE;
      fault_r    <= 1'b0;
`ifdef MOTOR_TIMEOUT_EN
      travel_r   <= TRAVEL_ZERO;
`endif
    end else begin
      state_r    <= state_s;
      dir_r      <= dir_s;
      duty_r     <= duty_s;
      div_r      <= div_s;
      dead_r     <= dead_s;
      pwm_cnt_r  <= pwm_cnt_r + DUTY_ONE;
      // dir_r is one-hot while driving, so the legs can never both be high.
      pwm_up_r   <= driving_s && (dir_r == DIR_UP)   && (pwm_cnt_r < duty_r);
      pwm_down_r <= driving_s && (dir_r == DIR_DOWN) && (pwm_cnt_r < duty_r);
      moving_r   <= driving_s ? dir_r : DIR_NONE;
`ifdef MOTOR_TIMEOUT_EN
      travel_r   <= travel_s;
      fault_r    <= (state_r == ST_FAULT);
`else
      fault_r    <= 1'b0;
`endif
    end
  end

  assign bus.PwmUp   = pwm_up_r;
  assign bus.PwmDown = pwm_down_r;
  assign bus.Moving  = moving_r;
  assign bus.Fault   = fault_r;

endmodule
